// File: rtl/shared_mem_ctrl.sv
// ============================================================================
// shared_mem_ctrl : two-port request arbiter in front of a single word array,
// one pending slot per port. Optional macro ARB_RR_EN selects round-robin.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef IOSTATEWIDTH
`define IOSTATEWIDTH 2
`endif
`ifndef IDEL
`define IDEL 2'b00
`endif
`ifndef RD
`define RD 2'b01
`endif
`ifndef WT
`define WT 2'b10
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif
`ifndef WORDWIDTH
`define WORDWIDTH 8
`endif

module shared_mem_ctrl #(
  parameter int LAT   = 3,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [`IOSTATEWIDTH-1:0] rw0,
  input  logic [`IOSTATEWIDTH-1:0] rw1,
  input  logic [`ADDRWIDTH-1:0]    addr0,
  input  logic [`ADDRWIDTH-1:0]    addr1,
  input  logic [`WORDWIDTH-1:0]    wdata0,
  input  logic [`WORDWIDTH-1:0]    wdata1,
  output logic [`WORDWIDTH-1:0]    rdata0,
  output logic [`WORDWIDTH-1:0]    rdata1,
  output logic                     readEn0,
  output logic                     readEn1,
  output logic                     writeDone0,
  output logic                     writeDone1,
  output logic [1:0]               err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       gnt, gnt_nxt, pick, grant_go, finish;

  logic [`WORDWIDTH-1:0] mem [DEPTH];

  logic [1:0]               slot_vld;
  logic [`IOSTATEWIDTH-1:0] slot_rw    [2];
  logic [`ADDRWIDTH-1:0]    slot_addr  [2];
  logic [`WORDWIDTH-1:0]    slot_wdata [2];

  logic [`IOSTATEWIDTH-1:0] rw_in    [2];
  logic [`ADDRWIDTH-1:0]    addr_in  [2];
  logic [`WORDWIDTH-1:0]    wdata_in [2];
  logic [1:0]               same;

  assign rw_in[0]    = rw0;
  assign rw_in[1]    = rw1;
  assign addr_in[0]  = addr0;
  assign addr_in[1]  = addr1;
  assign wdata_in[0] = wdata0;
  assign wdata_in[1] = wdata1;

  // A held request matching the pending one is a re-assertion, not an overrun.
  always_comb begin
    same = 2'b00;
    for (int p = 0; p < 2; p++) begin
      same[p] = (rw_in[p] == slot_rw[p]) && (addr_in[p] == slot_addr[p]) &&
                (wdata_in[p] == slot_wdata[p]);
    end
  end

`ifdef ARB_RR_EN
  logic last;
  assign pick = (slot_vld == 2'b11) ? ~last : ~slot_vld[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (grant_go) begin
      last <= gnt_nxt;
    end
  end
`else
  assign pick = ~slot_vld[0];
`endif

  // The array access and done pulse happen on the edge entering DONE, so the
  // pulse is visible during the DONE cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    grant_go  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (|slot_vld) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(LAT - 1);
          gnt_nxt   = pick;
          grant_go  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [AW-1:0] gidx;
  logic          fin_rd, fin_wt;

  assign gidx   = slot_addr[gnt][AW-1:0];
  assign fin_rd = finish && (slot_rw[gnt] == `RD);
  assign fin_wt = finish && (slot_rw[gnt] == `WT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      gnt        <= 1'b0;
      slot_vld   <= 2'b00;
      err        <= 2'b00;
      readEn0    <= 1'b0;
      readEn1    <= 1'b0;
      writeDone0 <= 1'b0;
      writeDone1 <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      gnt        <= gnt_nxt;
      readEn0    <= fin_rd && (gnt == 1'b0);
      readEn1    <= fin_rd && (gnt == 1'b1);
      writeDone0 <= fin_wt && (gnt == 1'b0);
      writeDone1 <= fin_wt && (gnt == 1'b1);
      if (fin_rd && (gnt == 1'b0)) rdata0 <= mem[gidx];
      if (fin_rd && (gnt == 1'b1)) rdata1 <= mem[gidx];
      for (int p = 0; p < 2; p++) begin
        if (rw_in[p] != `IDEL) begin
          if (!slot_vld[p]) begin
            slot_vld[p]   <= 1'b1;
            slot_rw[p]    <= rw_in[p];
            slot_addr[p]  <= addr_in[p];
            slot_wdata[p] <= wdata_in[p];
          end else if (!same[p]) begin
            err[p] <= 1'b1;
          end
        end
      end
      if (finish) slot_vld[gnt] <= 1'b0;
    end
  end

  // Storage has no reset; a write cut short by reset never lands.
  always_ff @(posedge clk) begin
    if (!reset && fin_wt) mem[gidx] <= slot_wdata[gnt];
  end

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_ctrl.sv
// ============================================================================
// tb_shared_mem_ctrl : directed table, corner sequences and randomized traffic
// against a transaction-timing reference model. Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef IOSTATEWIDTH
`define IOSTATEWIDTH 2
`endif
`ifndef IDEL
`define IDEL 2'b00
`endif
`ifndef RD
`define RD 2'b01
`endif
`ifndef WT
`define WT 2'b10
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif
`ifndef WORDWIDTH
`define WORDWIDTH 8
`endif

module tb_shared_mem_ctrl;

  localparam int LAT   = 3;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rw0 = `IDEL, rw1 = `IDEL;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [7:0] rdata0, rdata1;
  logic       readEn0, readEn1, writeDone0, writeDone1;
  logic [1:0] err;

  shared_mem_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .rdata0(rdata0), .rdata1(rdata1),
    .readEn0(readEn0), .readEn1(readEn1),
    .writeDone0(writeDone0), .writeDone1(writeDone1), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vec = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic [1:0] r, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin rw0 = r; addr0 = a; wdata0 = d; end
    else        begin rw1 = r; addr1 = a; wdata1 = d; end
  endtask

  function automatic logic pulse_of(input int p, input logic [1:0] r);
    if (r == `RD) return (p != 0) ? readEn1 : readEn0;
    return (p != 0) ? writeDone1 : writeDone0;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    drive(0, `IDEL, 8'h00, 8'h00);
    drive(1, `IDEL, 8'h00, 8'h00);
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Single isolated request: latency, single-cycle pulse, read data, other port untouched.
  task automatic txn(input int p, input logic [1:0] r, input logic [7:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd, input string nm);
    int lat;
    logic [7:0] other;
    @(negedge clk);
    other = (p != 0) ? rdata0 : rdata1;
    drive(p, r, a, d);
    @(negedge clk);
    drive(p, `IDEL, 8'h00, 8'h00);
    lat = -1;
    for (int i = 2; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (pulse_of(p, r)) lat = i - 1;
    end
    chk({nm, " latency"}, lat, LAT + 1);
    if (r == `RD) chk({nm, " rdata"}, (p != 0) ? rdata1 : rdata0, exp_rd);
    chk({nm, " other rdata"}, (p != 0) ? rdata0 : rdata1, other);
    @(negedge clk);
    chk({nm, " pulse width"}, pulse_of(p, r), 1'b0);
  endtask

  typedef struct {
    int         port;
    logic [1:0] rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  // Reference model: slot contents plus grant/completion edge numbers.
  logic [7:0] bmem [DEPTH];
  int         n_edge, m_port, m_done_at, m_free_at;
  bit         m_act, m_last;
  bit         m_occ [2];
  logic [1:0] m_rw [2];
  logic [7:0] m_ad [2], m_wd [2], m_rdata [2];
  bit         m_re [2], m_wp [2];
  logic [1:0] m_err;
  bit         in_rst;
  logic [1:0] in_rw [2];
  logic [7:0] in_ad [2], in_wd [2];

  task automatic model_step();
    bit old_occ [2];
    int p;
    int idx;
    n_edge++;
    m_re = '{0, 0};
    m_wp = '{0, 0};
    if (in_rst) begin
      m_occ = '{0, 0}; m_act = 0; m_free_at = n_edge; m_last = 1;
      m_rdata = '{8'h00, 8'h00}; m_err = 2'b00;
      return;
    end
    old_occ = m_occ;
    if (m_act && n_edge == m_done_at) begin
      p = m_port;
      idx = int'(m_ad[p]) % DEPTH;
      if (m_rw[p] == `RD) begin m_rdata[p] = bmem[idx]; m_re[p] = 1; end
      else begin bmem[idx] = m_wd[p]; m_wp[p] = 1; end
      m_occ[p] = 0;
      m_act = 0;
    end else if (!m_act && n_edge >= m_free_at && (old_occ[0] || old_occ[1])) begin
`ifdef ARB_RR_EN
      p = (old_occ[0] && old_occ[1]) ? (m_last ? 0 : 1) : (old_occ[0] ? 0 : 1);
`else
      p = old_occ[0] ? 0 : 1;
`endif
      m_act = 1; m_port = p; m_last = (p != 0);
      m_done_at = n_edge + LAT;
      m_free_at = n_edge + LAT + 2;
    end
    for (int q = 0; q < 2; q++) begin
      if (in_rw[q] != `IDEL) begin
        if (!old_occ[q]) begin
          m_occ[q] = 1; m_rw[q] = in_rw[q]; m_ad[q] = in_ad[q]; m_wd[q] = in_wd[q];
        end else if (in_rw[q] != m_rw[q] || in_ad[q] != m_ad[q] || in_wd[q] != m_wd[q]) begin
          m_err[q] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vec_t tbl [$];
    int   lat_a, lat_b, cnt;
    logic [7:0] keep;

    tbl.push_back('{0, `WT, 8'h05, 8'hA5, 8'h00});
    tbl.push_back('{0, `RD, 8'h05, 8'h00, 8'hA5});
    tbl.push_back('{1, `RD, 8'h05, 8'h00, 8'hA5});
    tbl.push_back('{1, `WT, 8'h13, 8'h5A, 8'h00});
    tbl.push_back('{0, `RD, 8'h03, 8'h00, 8'h5A});
    tbl.push_back('{1, `RD, 8'h23, 8'h00, 8'h5A});
    tbl.push_back('{0, `WT, 8'h07, 8'h33, 8'h00});
    tbl.push_back('{1, `WT, 8'hF0, 8'h3C, 8'h00});
    tbl.push_back('{1, `RD, 8'h00, 8'h00, 8'h3C});
    tbl.push_back('{0, `RD, 8'h17, 8'h00, 8'h33});
    tbl.push_back('{1, `WT, 8'h02, 8'h77, 8'h00});
    tbl.push_back('{1, `RD, 8'h02, 8'h00, 8'h77});

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset outputs", {readEn0, readEn1, writeDone0, writeDone1, err, rdata0, rdata1}, 32'h0);
    reset = 1'b0;

    foreach (tbl[i])
      txn(tbl[i].port, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("tbl%0d", i));

    // Same-edge write on port 0 and read of that address on port 1
    do_reset(2);
    @(negedge clk);
    keep = rdata0;
    drive(0, `WT, 8'h02, 8'h11);
    drive(1, `RD, 8'h02, 8'h00);
    @(negedge clk);
    drive(0, `IDEL, 8'h00, 8'h00);
    drive(1, `IDEL, 8'h00, 8'h00);
    lat_a = -1; lat_b = -1;
    for (int i = 2; i <= 30; i++) begin
      @(negedge clk);
      if (writeDone0 && lat_a < 0) lat_a = i - 1;
      if (readEn1 && lat_b < 0) lat_b = i - 1;
    end
    chk("tie write0 latency", lat_a, LAT + 1);
    chk("tie read1 latency", lat_b, 2 * LAT + 3);
    chk("tie rdata1", rdata1, 8'h11);
    chk("tie rdata0 held", rdata0, keep);

    // Overrun on port 1
    do_reset(2);
    @(negedge clk);
    drive(1, `RD, 8'h05, 8'h00);
    @(negedge clk);
    drive(1, `RD, 8'h06, 8'h00);
    @(negedge clk);
    drive(1, `IDEL, 8'h00, 8'h00);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (readEn1) cnt++;
    end
    chk("overrun completions", cnt, 1);
    chk("overrun rdata1", rdata1, 8'hA5);
    chk("overrun err", err, 2'b10);
    do_reset(1);
    @(negedge clk);
    chk("err cleared", err, 2'b00);

    // Reset aborts an in-flight write
    txn(0, `WT, 8'h07, 8'h33, 8'h00, "pre abort write");
    @(negedge clk);
    drive(0, `WT, 8'h07, 8'hFF);
    @(negedge clk);
    drive(0, `IDEL, 8'h00, 8'h00);
    cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (writeDone0) cnt++;
    end
    chk("aborted writeDone", cnt, 0);
    txn(0, `RD, 8'h07, 8'h00, 8'h33, "after abort read");

    // Port 0 held continuously while port 1 waits
    do_reset(2);
    @(negedge clk);
    drive(0, `RD, 8'h01, 8'h00);
    drive(1, `RD, 8'h02, 8'h00);
    @(negedge clk);
    drive(1, `IDEL, 8'h00, 8'h00);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (readEn1) cnt++;
    end
    chk("held request err", err, 2'b00);
`ifdef ARB_RR_EN
    chk("rr port1 served", cnt, 1);
    drive(0, `IDEL, 8'h00, 8'h00);
`else
    chk("fixed port1 starved", cnt, 0);
    drive(0, `IDEL, 8'h00, 8'h00);
    for (int i = 0; i < 30 && cnt == 0; i++) begin
      @(negedge clk);
      if (readEn1) cnt++;
    end
    chk("port1 served after release", cnt, 1);
    chk("port1 late rdata", rdata1, 8'h11);
`endif

    // Known array contents for the randomized phase
    for (int i = 0; i < DEPTH; i++) begin
      bmem[i] = 8'h80 + 8'(i * 7);
      txn(i % 2, `WT, 8'(i), bmem[i], 8'h00, "init write");
    end

    n_edge = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k > 0)
        chk($sformatf("random cycle %0d", k),
            {readEn0, readEn1, writeDone0, writeDone1, err, rdata0, rdata1},
            {m_re[0], m_re[1], m_wp[0], m_wp[1], m_err, m_rdata[0], m_rdata[1]});
      in_rst = (k == 0) || ($urandom_range(0, 149) == 0);
      for (int p = 0; p < 2; p++) begin
        if (k == 0) begin
          in_rw[p] = `IDEL; in_ad[p] = 8'h00; in_wd[p] = 8'h00;
        end else if ($urandom_range(0, 1) == 0) begin
          case ($urandom_range(0, 7))
            0, 1, 2, 3, 4: in_rw[p] = `IDEL;
            5:             in_rw[p] = `RD;
            default:       in_rw[p] = `WT;
          endcase
          in_ad[p] = 8'($urandom_range(0, 255));
          in_wd[p] = 8'($urandom);
        end
      end
      reset = in_rst;
      drive(0, in_rw[0], in_ad[0], in_wd[0]);
      drive(1, in_rw[1], in_ad[1], in_wd[1]);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shared_mem_ctrl.md
SHARED_MEM_CTRL -- requirements
Module: shared_mem_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 3, service latency in cycles from grant to done pulse (legal 1..15).
REQ-002 SHALL have parameter DEPTH, default 16, number of storage words, indexed by addr[log2(DEPTH)-1:0].
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 rw0, rw1  in  `IOSTATEWIDTH  per-port request code `RD / `WT / `IDEL; one cycle wide (pulse) or held.
REQ-006 addr0, addr1  in  `ADDRWIDTH  per-port request address.
REQ-007 wdata0, wdata1  in  `WORDWIDTH  per-port write data.
REQ-008 rdata0, rdata1  out  `WORDWIDTH  per-port read data.
REQ-009 readEn0, readEn1  out  1  per-port read-complete pulse.
REQ-010 writeDone0, writeDone1  out  1  per-port write-complete pulse.
REQ-011 err  out  2  sticky per-port overrun flag, bit0 = port 0, bit1 = port 1.

Function
REQ-012 SHALL capture a port request (rw, addr, wdata) into that port's one-entry pending slot on any rising edge where rw != `IDEL and the slot is empty.
REQ-013 SHALL set err[p] and discard the new request when rw_p != `IDEL while slot p is occupied; re-asserting the identical held request SHALL NOT set err.
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 IDLE -> BUSY when at least one slot is occupied; grant one slot, load latency counter with LAT-1.
REQ-016 BUSY: decrement counter each cycle; at zero -> DONE.
REQ-017 DONE (one cycle): for `WT, write wdata into the array and pulse writeDone_p; for `RD, load rdata_p from the array and pulse readEn_p. Clear slot p. -> IDLE.
REQ-018 Done pulses SHALL be exactly one cycle and registered; with an empty pending slot, the granted request's pulse SHALL appear LAT+1 cycles after the capture edge.
REQ-019 rdata_p SHALL hold its value until the next read completion on port p; a completion on the other port SHALL NOT change it.
REQ-020 Requests SHALL be serviced one at a time in grant order; a read granted after a write to the same address SHALL return the written data.
REQ-021 Both slots occupied in IDLE: arbitration per REQ-027/REQ-028; the losing slot is granted on the next IDLE entry.
REQ-022 A capture on a port while the other port is BUSY SHALL be held pending; no request is ever lost except per REQ-013.
REQ-023 Address bits above log2(DEPTH) SHALL be ignored (aliasing wrap-around).

Reset
REQ-024 reset SHALL force: FSM IDLE, both slots empty, counter 0, readEn*/writeDone* 0, rdata* 0, err 0, last-grant pointer = port 1.
REQ-025 reset asserted mid-operation SHALL abort the in-flight request with no done pulse; an aborted write SHALL NOT modify the array.
REQ-026 Storage array contents SHALL NOT be affected by reset.

Configuration
REQ-027 With ARB_RR_EN defined: round-robin; on a tie the port not granted last wins, pointer updates on each grant (port 0 wins the first tie after reset).
REQ-028 Without ARB_RR_EN: fixed priority; on a tie port 0 always wins, pointer unused.

Verification
REQ-029 LAT=3; port 0 `WT addr 5 data 0xA5 pulsed one cycle -> writeDone0 high exactly 4 cycles after capture, one cycle; then `RD addr 5 -> readEn0 pulse, rdata0 = 0xA5.
REQ-030 Same edge: port 0 `WT addr 2 = 0x11, port 1 `RD addr 2 -> port 0 done first, port 1 readEn1 with rdata1 = 0x11; rdata0 unchanged.
REQ-031 ARB_RR_EN defined: three back-to-back simultaneous request pairs -> grants 0,1,0,1,0,1; undefined -> 0,1,0,1,0,1 only because slot 1 waits, and port 1 starves when port 0 re-requests every capture.
REQ-032 Port 1 second `RD while its slot occupied -> err = 2'b10, first request still completes, second never completes; reset clears err.
REQ-033 Reset asserted 2 cycles into a `WT addr 7 = 0xFF (prior value 0x33) -> no writeDone, subsequent `RD addr 7 returns 0x33.
REQ-034 `WT addr 0x13 = 0x5A with DEPTH=16 -> `RD addr 3 returns 0x5A.
